// File: rtl/g1_hazard_scoreboard.sv
// rtl/g1_hazard_scoreboard.sv - RAW hazard scoreboard with stall, IF flush and bypass selects
//
// Purpose:
//   Tracks destination registers of instructions in flight behind ID in a
//   DEPTH-deep shadow pipeline (stage 1 = EXE ... stage DEPTH = WB) and
//   resolves read-after-write hazards for the instruction currently in ID.
//
// Build option:
//   G1_HAZ_FORWARD_EN  defined   -> bypass from the youngest matching stage,
//                                   stall only on loads not yet bypassable.
//                      undefined -> any in-flight match stalls, no bypass.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_valid                 ID holds a real instruction
//   id_src1/_used            operand 1 register and read flag
//   id_src2/_used            operand 2 register and read flag
//   id_dest, id_wb_en        destination register and write-back flag
//   id_mem_r_en              instruction in ID is a load
//   br_taken                 branch resolved taken in ID
//   stall                    freeze PC and IF/ID, bubble into EXE
//   issue                    id_valid & ~stall
//   flush_if                 clear IF/ID
//   fwd_sel1, fwd_sel2       0 = register file, k = stage-k result bus
//   stall_cycles             saturating count of stalled cycles

module g1_hazard_scoreboard #(
    parameter int REG_ADDR_W = 4,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    parameter int R0_ZERO    = 1,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic                  id_src1_used,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_src2_used,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_wb_en,
    input  logic                  id_mem_r_en,
    input  logic                  br_taken,
    output logic                  stall,
    output logic                  issue,
    output logic                  flush_if,
    output logic [SEL_W-1:0]      fwd_sel1,
    output logic [SEL_W-1:0]      fwd_sel2,
    output logic [CNT_W-1:0]      stall_cycles
);

`ifdef G1_HAZ_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    // Shadow pipeline state, index k = stage k after ID.
    logic [DEPTH:1]          v_q, v_d;
    logic [DEPTH:1]          wb_q, wb_d;
    logic [DEPTH:1]          ld_q, ld_d;
    logic [REG_ADDR_W-1:0]   dest_q [1:DEPTH];
    logic [REG_ADDR_W-1:0]   dest_d [1:DEPTH];
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    // Per-operand resolution results.
    logic                    hit1, hit2;
    logic                    ld_haz1, ld_haz2;
    logic [SEL_W-1:0]        sel1, sel2;
    logic                    src1_zero, src2_zero;
    logic                    op_stall1, op_stall2;

    assign src1_zero = (R0_ZERO != 0) && (id_src1 == '0);
    assign src2_zero = (R0_ZERO != 0) && (id_src2 == '0);

    // Scan oldest to youngest so the youngest (lowest k) match overwrites
    // any older one and ends up as the winner.
    always_comb begin
        hit1    = 1'b0;
        hit2    = 1'b0;
        ld_haz1 = 1'b0;
        ld_haz2 = 1'b0;
        sel1    = '0;
        sel2    = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (v_q[k] && wb_q[k] && (dest_q[k] == id_src1) && id_src1_used && !src1_zero) begin
                hit1    = 1'b1;
                sel1    = SEL_W'(k);
                ld_haz1 = ld_q[k] && (k < LOAD_READY);
            end
            if (v_q[k] && wb_q[k] && (dest_q[k] == id_src2) && id_src2_used && !src2_zero) begin
                hit2    = 1'b1;
                sel2    = SEL_W'(k);
                ld_haz2 = ld_q[k] && (k < LOAD_READY);
            end
        end
    end

    // With bypass only a too-young load blocks; without it any match must
    // wait for the producer to reach the register file.
    assign op_stall1 = FWD_EN ? ld_haz1 : hit1;
    assign op_stall2 = FWD_EN ? ld_haz2 : hit2;

    assign stall        = id_valid & (op_stall1 | op_stall2);
    assign issue        = id_valid & ~stall;
    assign flush_if     = br_taken & id_valid & ~stall;
    assign fwd_sel1     = FWD_EN ? sel1 : '0;
    assign fwd_sel2     = FWD_EN ? sel2 : '0;
    assign stall_cycles = cnt_q;

    // Stage 1 takes the issuing instruction or a bubble; older stages
    // always advance since nothing past ID ever freezes.
    always_comb begin
        v_d       = '0;
        wb_d      = '0;
        ld_d      = '0;
        dest_d    = dest_q;
        v_d[1]    = issue;
        wb_d[1]   = id_wb_en;
        ld_d[1]   = id_mem_r_en;
        dest_d[1] = id_dest;
        for (int k = 2; k <= DEPTH; k++) begin
            v_d[k]    = v_q[k-1];
            wb_d[k]   = wb_q[k-1];
            ld_d[k]   = ld_q[k-1];
            dest_d[k] = dest_q[k-1];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            wb_q  <= '0;
            ld_q  <= '0;
            cnt_q <= '0;
        end else begin
            v_q   <= v_d;
            wb_q  <= wb_d;
            ld_q  <= ld_d;
            cnt_q <= cnt_d;
        end
    end

    // Destination fields are qualified by v_q, so they need no reset.
    always_ff @(posedge clk) begin
        dest_q <= dest_d;
    end

endmodule

// File: tb/tb_g1_hazard_scoreboard.sv
// tb/tb_g1_hazard_scoreboard.sv - directed self-checking bench for g1_hazard_scoreboard

module tb_g1_hazard_scoreboard;

`ifdef G1_HAZ_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam int RW   = 4;
    localparam int CW   = 8;
    // Stall cycles for a one-cycle-old producer: load-use costs 1 with
    // bypass; without bypass the consumer waits for all 3 stages to drain.
    localparam int NST_ALU  = FWD ? 0 : 3;
    localparam int NST_LOAD = FWD ? 1 : 3;

    logic          clk;
    logic          rst;
    logic          id_valid;
    logic [RW-1:0] id_src1;
    logic          id_src1_used;
    logic [RW-1:0] id_src2;
    logic          id_src2_used;
    logic [RW-1:0] id_dest;
    logic          id_wb_en;
    logic          id_mem_r_en;
    logic          br_taken;
    logic          stall;
    logic          issue;
    logic          flush_if;
    logic [1:0]    fwd_sel1;
    logic [1:0]    fwd_sel2;
    logic [CW-1:0] stall_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    g1_hazard_scoreboard #(
        .REG_ADDR_W(RW),
        .DEPTH(3),
        .LOAD_READY(2),
        .R0_ZERO(1),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .id_valid(id_valid),
        .id_src1(id_src1),
        .id_src1_used(id_src1_used),
        .id_src2(id_src2),
        .id_src2_used(id_src2_used),
        .id_dest(id_dest),
        .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en),
        .br_taken(br_taken),
        .stall(stall),
        .issue(issue),
        .flush_if(flush_if),
        .fwd_sel1(fwd_sel1),
        .fwd_sel2(fwd_sel2),
        .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [RW-1:0] s1, input logic u1,
                          input logic [RW-1:0] s2, input logic u2, input logic [RW-1:0] d,
                          input logic wb, input logic ld, input logic br);
        id_valid     = v;
        id_src1      = s1;
        id_src1_used = u1;
        id_src2      = s2;
        id_src2_used = u2;
        id_dest      = d;
        id_wb_en     = wb;
        id_mem_r_en  = ld;
        br_taken     = br;
    endtask

    task automatic do_reset();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        do_reset();
        #1;
        check("rst_stall", stall, 0);
        check("rst_flush", flush_if, 0);
        check("rst_issue", issue, 0);
        check("rst_fwd1", fwd_sel1, 0);
        check("rst_fwd2", fwd_sel2, 0);
        check("rst_cnt", stall_cycles, 0);

        // ALU producer r5 followed by a consumer of r5
        set_id(1, 0, 0, 0, 0, 5, 1, 0, 0);
        #1;
        check("alu_issue", issue, 1);
        tick();
        set_id(1, 5, 1, 0, 0, 6, 1, 0, 0);
        #1;
        for (int i = 0; i < NST_ALU; i++) begin
            check("alu_stall", stall, 1);
            check("alu_noissue", issue, 0);
            tick();
        end
        check("alu_go_stall", stall, 0);
        check("alu_go_issue", issue, 1);
        check("alu_fwd1", fwd_sel1, FWD ? 1 : 0);
        check("alu_cnt", stall_cycles, NST_ALU);

        // Load r3 followed by a consumer on operand 2
        do_reset();
        set_id(1, 0, 0, 0, 0, 3, 1, 1, 0);
        tick();
        set_id(1, 0, 0, 3, 1, 4, 1, 0, 0);
        #1;
        for (int i = 0; i < NST_LOAD; i++) begin
            check("lu_stall", stall, 1);
            tick();
        end
        check("lu_go_stall", stall, 0);
        check("lu_go_issue", issue, 1);
        check("lu_fwd2", fwd_sel2, FWD ? 2 : 0);
        check("lu_cnt", stall_cycles, NST_LOAD);

        // Older producer alone in stage 3
        do_reset();
        set_id(1, 0, 0, 0, 0, 7, 1, 0, 0);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        set_id(0, 7, 1, 0, 0, 0, 0, 0, 0);
        #1;
        check("old_fwd1", fwd_sel1, FWD ? 3 : 0);
        check("old_novalid_stall", stall, 0);

        // r7 in stage 3 and stage 1: youngest wins
        do_reset();
        set_id(1, 0, 0, 0, 0, 7, 1, 0, 0);
        tick();
        set_id(1, 0, 0, 0, 0, 2, 1, 0, 0);
        tick();
        set_id(1, 0, 0, 0, 0, 7, 1, 0, 0);
        tick();
        set_id(0, 7, 1, 0, 0, 0, 0, 0, 0);
        #1;
        check("young_fwd1", fwd_sel1, FWD ? 1 : 0);
        id_valid = 1'b1;
        #1;
        check("young_stall", stall, FWD ? 0 : 1);

        // r0 never hazards
        do_reset();
        set_id(1, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        set_id(1, 0, 1, 0, 1, 1, 1, 0, 0);
        #1;
        check("r0_stall", stall, 0);
        check("r0_fwd1", fwd_sel1, 0);
        check("r0_fwd2", fwd_sel2, 0);

        // Unused operands never hazard
        do_reset();
        set_id(1, 0, 0, 0, 0, 5, 1, 0, 0);
        tick();
        set_id(1, 5, 0, 5, 0, 1, 1, 0, 0);
        #1;
        check("unused_stall", stall, 0);
        check("unused_fwd1", fwd_sel1, 0);
        check("unused_fwd2", fwd_sel2, 0);

        // Producer without write-back never matches
        do_reset();
        set_id(1, 0, 0, 0, 0, 5, 0, 0, 0);
        tick();
        set_id(1, 5, 1, 5, 1, 1, 1, 0, 0);
        #1;
        check("nowb_stall", stall, 0);
        check("nowb_fwd1", fwd_sel1, 0);
        check("nowb_fwd2", fwd_sel2, 0);

        // Taken branch with no hazard flushes immediately
        do_reset();
        set_id(1, 0, 0, 0, 0, 2, 1, 0, 1);
        #1;
        check("br_flush", flush_if, 1);
        check("br_issue", issue, 1);

        // Taken branch held behind a load-use stall
        do_reset();
        set_id(1, 0, 0, 0, 0, 3, 1, 1, 0);
        tick();
        set_id(1, 3, 1, 0, 0, 0, 0, 0, 1);
        #1;
        for (int i = 0; i < NST_LOAD; i++) begin
            check("brst_flush", flush_if, 0);
            check("brst_stall", stall, 1);
            tick();
        end
        check("brst_flush_after", flush_if, 1);

        // Reset in the middle of a load-use stall
        do_reset();
        set_id(1, 0, 0, 0, 0, 3, 1, 1, 0);
        tick();
        set_id(1, 3, 1, 0, 0, 4, 1, 0, 0);
        #1;
        check("mid_stall", stall, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("postrst_stall", stall, 0);
        check("postrst_cnt", stall_cycles, 0);
        check("postrst_fwd1", fwd_sel1, 0);
        check("postrst_issue", issue, 1);

        // Reset overrides a simultaneous issue
        set_id(1, 0, 0, 0, 0, 3, 1, 1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_id(1, 3, 1, 0, 0, 4, 1, 0, 0);
        #1;
        check("rstovr_stall", stall, 0);
        check("rstovr_fwd1", fwd_sel1, 0);

        // Counter saturation: self-dependent load chain keeps stalling
        do_reset();
        set_id(1, 3, 1, 0, 0, 3, 1, 1, 0);
        repeat (700) tick();
        check("sat_cnt", stall_cycles, 255);
        repeat (8) tick();
        check("sat_hold", stall_cycles, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
